// File: rtl/terminal_memtest_pkg.sv
// Shared types, defaults and the address-derived test pattern for the
// terminal RAM self-test master.
package terminal_memtest_pkg;

   localparam int DEF_ADDR_W = 13;
   localparam int DEF_DATA_W = 64;

   // Sequencer states: fill phase, read phase, one drain cycle for the last
   // compare, then a one-cycle completion state.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_CHECK = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FIN   = 3'd4
   } state_e;

   localparam logic [1:0] MODE_NOP   = 2'b00;
   localparam logic [1:0] MODE_FILL  = 2'b01;
   localparam logic [1:0] MODE_CHECK = 2'b10;
   localparam logic [1:0] MODE_BOTH  = 2'b11;

   // P(a) = {seed ^ a, ~(seed ^ a)}, upper word first; a is zero-extended.
   function automatic logic [63:0] pattern(input logic [31:0] seed,
                                           input logic [31:0] a);
      logic [31:0] x;
      x = seed ^ a;
      return {x, ~x};
   endfunction

endpackage

// File: rtl/terminal_memtest_cmp.sv
// Read-side checker: carries the expected word and its address alongside
// each outstanding read for RD_LATENCY cycles, compares against readdata
// when the slave returns it, and keeps the sticky error state.
module terminal_memtest_cmp
   import terminal_memtest_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              flush,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic [DATA_W-1:0] issue_exp,
   input  logic [DATA_W-1:0] readdata,
   output logic              mismatch,
   output logic              err_flag,
   output logic [ADDR_W-1:0] err_addr,
   output logic [15:0]       err_count
);

   logic [RD_LATENCY-1:0] vld_q, vld_d;
   logic [DATA_W-1:0]     exp_q [RD_LATENCY];
   logic [DATA_W-1:0]     exp_d [RD_LATENCY];
   logic [ADDR_W-1:0]     adr_q [RD_LATENCY];
   logic [ADDR_W-1:0]     adr_d [RD_LATENCY];
   logic                  err_flag_q, err_flag_d;
   logic [ADDR_W-1:0]     err_addr_q, err_addr_d;
   logic [15:0]           err_count_q, err_count_d;

   // The oldest pipeline stage lines up with the slave's readdata.
   assign mismatch = vld_q[RD_LATENCY-1] && (readdata != exp_q[RD_LATENCY-1]);

   // Shift expected value / address / valid one stage per cycle; a flush
   // kills every read still in flight, including the one issued now.
   always_comb begin
      vld_d    = '0;
      vld_d[0] = issue_valid;
      exp_d[0] = issue_exp;
      adr_d[0] = issue_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         exp_d[i] = exp_q[i-1];
         adr_d[i] = adr_q[i-1];
      end
      if (flush) begin
         vld_d = '0;
      end
   end

   // Error capture: first mismatch address, sticky flag, saturating count.
   always_comb begin
      err_flag_d  = err_flag_q;
      err_addr_d  = err_addr_q;
      err_count_d = err_count_q;
      if (clear) begin
         err_flag_d  = 1'b0;
         err_addr_d  = '0;
         err_count_d = '0;
      end else if (mismatch) begin
         err_flag_d = 1'b1;
         if (!err_flag_q) begin
            err_addr_d = adr_q[RD_LATENCY-1];
         end
         if (err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
         end
      end
   end

   // Pipeline and error registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q       <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            exp_q[i] <= '0;
            adr_q[i] <= '0;
         end
         err_flag_q  <= 1'b0;
         err_addr_q  <= '0;
         err_count_q <= '0;
      end else begin
         vld_q       <= vld_d;
         exp_q       <= exp_d;
         adr_q       <= adr_d;
         err_flag_q  <= err_flag_d;
         err_addr_q  <= err_addr_d;
         err_count_q <= err_count_d;
      end
   end

   assign err_flag  = err_flag_q;
   assign err_addr  = err_addr_q;
   assign err_count = err_count_q;

endmodule

// File: rtl/terminal_memtest_master.sv
// Avalon-MM fixed-latency master that fills a word range of the terminal
// RAM with an address-derived pattern and/or reads it back and checks it.
// Build option: TERMINAL_MEMTEST_STOP_ON_ERR_EN makes the first mismatch
// abort the read phase (in-flight reads discarded, exit via DRAIN).
module terminal_memtest_master
   import terminal_memtest_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W:0]       length,
   input  logic [31:0]           seed,
   output logic                  busy,
   output logic                  done,
   output logic                  err_flag,
   output logic [ADDR_W-1:0]     err_addr,
   output logic [15:0]           err_count,
   output logic [ADDR_W-1:0]     address,
   output logic [DATA_W/8-1:0]   byteenable,
   output logic                  chipselect,
   output logic                  write,
   output logic [DATA_W-1:0]     writedata,
   output logic                  clken,
   input  logic [DATA_W-1:0]     readdata
);

`ifdef TERMINAL_MEMTEST_STOP_ON_ERR_EN
   localparam bit STOP_ON_ERR = 1'b1;
`else
   localparam bit STOP_ON_ERR = 1'b0;
`endif

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [31:0]       seed_q, seed_d;
   logic [1:0]        mode_q, mode_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;

   logic              clear;
   logic              flush;
   logic              issue_valid;
   logic              mismatch;
   logic              cs;
   logic              wr;
   logic [DATA_W-1:0] cur_pat;

   assign cur_pat = DATA_W'(pattern(seed_q, 32'(addr_q)));

   // Next-state, parameter latching and bus-cycle decode.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      seed_d      = seed_q;
      mode_d      = mode_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      clear       = 1'b0;
      flush       = 1'b0;
      issue_valid = 1'b0;
      cs          = 1'b0;
      wr          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (mode != MODE_NOP && length != '0) begin
                  base_d  = base_addr;
                  len_d   = length;
                  seed_d  = seed;
                  mode_d  = mode;
                  addr_d  = base_addr;
                  cnt_d   = length;
                  clear   = 1'b1;
                  state_d = mode[0] ? ST_FILL : ST_CHECK;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_FILL: begin
            cs     = 1'b1;
            wr     = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - (ADDR_W+1)'(1);
            if (cnt_q == (ADDR_W+1)'(1)) begin
               if (mode_q == MODE_BOTH) begin
                  addr_d  = base_q;
                  cnt_d   = len_q;
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_CHECK: begin
            cs          = 1'b1;
            issue_valid = 1'b1;
            addr_d      = addr_q + ADDR_W'(1);
            cnt_d       = cnt_q - (ADDR_W+1)'(1);
            if (STOP_ON_ERR && mismatch) begin
               flush   = 1'b1;
               state_d = ST_DRAIN;
            end else if (cnt_q == (ADDR_W+1)'(1)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_d = ST_FIN;
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         len_q   <= '0;
         seed_q  <= '0;
         mode_q  <= MODE_NOP;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         seed_q  <= seed_d;
         mode_q  <= mode_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   terminal_memtest_cmp #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .RD_LATENCY (RD_LATENCY)
   ) u_cmp (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_addr  (addr_q),
      .issue_exp   (cur_pat),
      .readdata    (readdata),
      .mismatch    (mismatch),
      .err_flag    (err_flag),
      .err_addr    (err_addr),
      .err_count   (err_count)
   );

   // Bus and status outputs; address/data are parked at zero between accesses.
   always_comb begin
      chipselect = cs;
      write      = wr;
      address    = cs ? addr_q : '0;
      writedata  = wr ? cur_pat : '0;
      byteenable = '1;
      clken      = 1'b1;
      busy       = (state_q == ST_FILL) || (state_q == ST_CHECK) || (state_q == ST_DRAIN);
      done       = (state_q == ST_FIN);
   end

endmodule

// File: tb/tb_terminal_memtest_master.sv
// Bench for terminal_memtest_master: ideal 1-cycle-latency RAM model with
// per-word bit-0 corruption, expected bus transactions queued at start.
module tb_terminal_memtest_master;

   localparam int AW = 13;
   localparam int DW = 64;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } bus_t;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic [1:0]      mode = 2'b00;
   logic [AW-1:0]   base_addr = '0;
   logic [AW:0]     length = '0;
   logic [31:0]     seed = '0;
   logic            busy, done, err_flag;
   logic [AW-1:0]   err_addr;
   logic [15:0]     err_count;
   logic [AW-1:0]   address;
   logic [DW/8-1:0] byteenable;
   logic            chipselect, write, clken;
   logic [DW-1:0]   writedata;
   logic [DW-1:0]   readdata;

   logic [DW-1:0]   mem [1<<AW];
   bit              corrupt [1<<AW];
   logic [DW-1:0]   rd_q;

   bus_t            exp_q[$];
   bus_t            obs_q[$];
   int              checks = 0;
   int              errors = 0;
   int              done_cyc;
   int              done_cnt;
   logic            busy_first;
   logic            busy_at_done;

   always #5 clk = ~clk;

   terminal_memtest_master dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .mode       (mode),
      .base_addr  (base_addr),
      .length     (length),
      .seed       (seed),
      .busy       (busy),
      .done       (done),
      .err_flag   (err_flag),
      .err_addr   (err_addr),
      .err_count  (err_count),
      .address    (address),
      .byteenable (byteenable),
      .chipselect (chipselect),
      .write      (write),
      .writedata  (writedata),
      .clken      (clken),
      .readdata   (readdata)
   );

   // RAM slave model
   always @(posedge clk) begin
      if (chipselect && write) mem[address] <= writedata;
      rd_q <= mem[address] ^ (corrupt[address] ? 64'h1 : 64'h0);
   end
   assign readdata = rd_q;

   function automatic logic [DW-1:0] pat(input logic [31:0] s, input logic [AW-1:0] a);
      logic [31:0] x;
      x = s ^ {19'd0, a};
      return {x, ~x};
   endfunction

   task automatic push_exp(input logic we, input logic [AW-1:0] b, input int n, input logic [31:0] s);
      bus_t t;
      logic [AW-1:0] a;
      a = b;
      for (int i = 0; i < n; i++) begin
         t.we   = we;
         t.addr = a;
         t.data = we ? pat(s, a) : '0;
         exp_q.push_back(t);
         a = a + 13'd1;
      end
   endtask

   // Issues one start and records bus activity and done timing (cycle 1 is
   // the cycle after the accepting edge). Optionally pulses a second start.
   task automatic run_op(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW:0] len,
                         input logic [31:0] s, input int budget, input int restart_cyc);
      int cyc;
      bus_t o;
      obs_q.delete();
      done_cyc = -1;
      done_cnt = 0;
      busy_first = 1'b0;
      busy_at_done = 1'b1;
      @(negedge clk);
      start = 1'b1; mode = m; base_addr = b; length = len; seed = s;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc <= budget) begin
         if (cyc == 1) busy_first = busy;
         if (cyc == restart_cyc) begin
            start = 1'b1; mode = 2'b01; base_addr = 13'h1000; length = 14'd2; seed = 32'h0;
         end else begin
            start = 1'b0;
         end
         if (chipselect) begin
            o.we = write; o.addr = address; o.data = write ? writedata : '0;
            obs_q.push_back(o);
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               busy_at_done = busy;
            end
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err_flag !== 1'b0) begin
         errors++; $display("FAIL reset_status got busy=%b done=%b err=%b exp 0 0 0", busy, done, err_flag);
      end
      checks++;
      if (chipselect !== 1'b0 || write !== 1'b0) begin
         errors++; $display("FAIL reset_bus_ctl got cs=%b wr=%b exp 0 0", chipselect, write);
      end
      checks++;
      if (address !== '0 || writedata !== '0 || err_addr !== '0 || err_count !== '0) begin
         errors++; $display("FAIL reset_values got a=%h wd=%h ea=%h ec=%h exp all 0", address, writedata, err_addr, err_count);
      end
      checks++;
      if (byteenable !== 8'hFF || clken !== 1'b1) begin
         errors++; $display("FAIL reset_be_clken got be=%h clken=%b exp ff 1", byteenable, clken);
      end
   endtask

   task automatic test_fill_check();
      bus_t e, o;
      push_exp(1'b1, 13'h0, 16, 32'hA5A5A5A5);
      push_exp(1'b0, 13'h0, 16, 32'hA5A5A5A5);
      run_op(2'b11, 13'h0, 14'd16, 32'hA5A5A5A5, 60, 0);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL fill_check bus_count got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            errors++; $display("FAIL fill_check bus got we=%b a=%h d=%h exp we=%b a=%h d=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
         end
      end
      exp_q.delete(); obs_q.delete();
      checks++;
      if (mem[3] !== 64'hA5A5A5A6_5A5A5A59) begin
         errors++; $display("FAIL fill_check word3 got %h exp a5a5a5a65a5a5a59", mem[3]);
      end
      checks++;
      if (done_cyc !== 34 || done_cnt !== 1) begin
         errors++; $display("FAIL fill_check done got cyc=%0d n=%0d exp 34 1", done_cyc, done_cnt);
      end
      checks++;
      if (busy_first !== 1'b1 || busy_at_done !== 1'b0) begin
         errors++; $display("FAIL fill_check busy got first=%b at_done=%b exp 1 0", busy_first, busy_at_done);
      end
      checks++;
      if (err_flag !== 1'b0 || err_count !== 16'd0) begin
         errors++; $display("FAIL fill_check err got flag=%b cnt=%0d exp 0 0", err_flag, err_count);
      end
   endtask

   task automatic test_check_errors();
      bus_t e, o;
      int exp_reads, exp_done;
      logic [15:0] exp_cnt;
`ifdef TERMINAL_MEMTEST_STOP_ON_ERR_EN
      exp_reads = 7; exp_done = 9; exp_cnt = 16'd1;
`else
      exp_reads = 16; exp_done = 18; exp_cnt = 16'd2;
`endif
      push_exp(1'b1, 13'h0, 16, 32'h12345678);
      run_op(2'b01, 13'h0, 14'd16, 32'h12345678, 40, 0);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL fill_only bus_count got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            errors++; $display("FAIL fill_only bus got we=%b a=%h d=%h exp we=%b a=%h d=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
         end
      end
      exp_q.delete(); obs_q.delete();
      checks++;
      if (done_cyc !== 17) begin
         errors++; $display("FAIL fill_only done got %0d exp 17", done_cyc);
      end
      corrupt[5] = 1'b1;
      corrupt[9] = 1'b1;
      push_exp(1'b0, 13'h0, exp_reads, 32'h12345678);
      run_op(2'b10, 13'h0, 14'd16, 32'h12345678, 40, 0);
      corrupt[5] = 1'b0;
      corrupt[9] = 1'b0;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL check_err bus_count got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            errors++; $display("FAIL check_err bus got we=%b a=%h exp we=%b a=%h", o.we, o.addr, e.we, e.addr);
         end
      end
      exp_q.delete(); obs_q.delete();
      checks++;
      if (done_cyc !== exp_done || done_cnt !== 1) begin
         errors++; $display("FAIL check_err done got cyc=%0d n=%0d exp %0d 1", done_cyc, done_cnt, exp_done);
      end
      checks++;
      if (err_flag !== 1'b1 || err_addr !== 13'h0005 || err_count !== exp_cnt) begin
         errors++; $display("FAIL check_err err got flag=%b addr=%h cnt=%0d exp 1 0005 %0d", err_flag, err_addr, err_count, exp_cnt);
      end
   endtask

   task automatic test_wrap();
      bus_t e, o;
      push_exp(1'b1, 13'h1FFE, 4, 32'hC0FFEE00);
      push_exp(1'b0, 13'h1FFE, 4, 32'hC0FFEE00);
      run_op(2'b11, 13'h1FFE, 14'd4, 32'hC0FFEE00, 30, 0);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL wrap bus_count got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            errors++; $display("FAIL wrap bus got we=%b a=%h d=%h exp we=%b a=%h d=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
         end
      end
      exp_q.delete(); obs_q.delete();
      checks++;
      if (done_cyc !== 10 || err_flag !== 1'b0 || err_count !== 16'd0 || err_addr !== '0) begin
         errors++; $display("FAIL wrap result got done=%0d flag=%b cnt=%0d addr=%h exp 10 0 0 0", done_cyc, err_flag, err_count, err_addr);
      end
   endtask

   task automatic test_nop();
      run_op(2'b11, 13'h10, 14'd0, 32'h1, 10, 0);
      checks++;
      if (obs_q.size() != 0 || done_cyc !== 1 || done_cnt !== 1) begin
         errors++; $display("FAIL len0 got bus=%0d done=%0d n=%0d exp 0 1 1", obs_q.size(), done_cyc, done_cnt);
      end
      run_op(2'b00, 13'h10, 14'd5, 32'h1, 10, 0);
      checks++;
      if (obs_q.size() != 0 || done_cyc !== 1 || done_cnt !== 1) begin
         errors++; $display("FAIL mode00 got bus=%0d done=%0d n=%0d exp 0 1 1", obs_q.size(), done_cyc, done_cnt);
      end
      obs_q.delete();
   endtask

   task automatic test_reset_mid();
      bus_t e, o;
      int dn;
      dn = 0;
      @(negedge clk);
      start = 1'b1; mode = 2'b01; base_addr = 13'h100; length = 14'd100; seed = 32'hDEADBEEF;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c < 5; c++) begin
         if (done) dn++;
         @(negedge clk);
      end
      checks++;
      if (chipselect !== 1'b1 || write !== 1'b1 || address !== 13'h104) begin
         errors++; $display("FAIL reset_mid 5th_write got cs=%b wr=%b a=%h exp 1 1 0104", chipselect, write, address);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (chipselect !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL reset_mid idle got cs=%b busy=%b done=%b exp 0 0 0", chipselect, busy, done);
      end
      reset = 1'b0;
      repeat (6) begin
         if (done) dn++;
         @(negedge clk);
      end
      checks++;
      if (dn !== 0) begin
         errors++; $display("FAIL reset_mid done_pulses got %0d exp 0", dn);
      end
      push_exp(1'b1, 13'h20, 3, 32'h0BADF00D);
      push_exp(1'b0, 13'h20, 3, 32'h0BADF00D);
      run_op(2'b11, 13'h20, 14'd3, 32'h0BADF00D, 30, 0);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL reset_mid_restart bus_count got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            errors++; $display("FAIL reset_mid_restart bus got we=%b a=%h d=%h exp we=%b a=%h d=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
         end
      end
      exp_q.delete(); obs_q.delete();
      checks++;
      if (done_cyc !== 8 || done_cnt !== 1 || err_flag !== 1'b0) begin
         errors++; $display("FAIL reset_mid_restart got done=%0d n=%0d err=%b exp 8 1 0", done_cyc, done_cnt, err_flag);
      end
   endtask

   task automatic test_start_while_busy();
      bus_t e, o;
      push_exp(1'b1, 13'h40, 8, 32'h5555AAAA);
      push_exp(1'b0, 13'h40, 8, 32'h5555AAAA);
      run_op(2'b11, 13'h40, 14'd8, 32'h5555AAAA, 40, 3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL busy_start bus_count got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            errors++; $display("FAIL busy_start bus got we=%b a=%h d=%h exp we=%b a=%h d=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
         end
      end
      exp_q.delete(); obs_q.delete();
      checks++;
      if (done_cyc !== 18 || done_cnt !== 1) begin
         errors++; $display("FAIL busy_start done got cyc=%0d n=%0d exp 18 1", done_cyc, done_cnt);
      end
   endtask

   task automatic test_random();
      bus_t e, o;
      logic [AW-1:0] b;
      int n;
      logic [31:0] s;
      for (int k = 0; k < 3; k++) begin
         b = AW'($urandom_range(0, 8191));
         n = $urandom_range(1, 40);
         s = $urandom;
         push_exp(1'b1, b, n, s);
         push_exp(1'b0, b, n, s);
         run_op(2'b11, b, (AW+1)'(n), s, 2 * n + 10, 0);
         checks++;
         if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random bus_count got %0d exp %0d", obs_q.size(), exp_q.size());
         end
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
               errors++; $display("FAIL random bus got we=%b a=%h d=%h exp we=%b a=%h d=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
         end
         exp_q.delete(); obs_q.delete();
         checks++;
         if (done_cyc !== 2 * n + 2 || err_flag !== 1'b0) begin
            errors++; $display("FAIL random result got done=%0d err=%b exp %0d 0", done_cyc, err_flag, 2 * n + 2);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      test_reset();
      reset = 1'b0;
      test_fill_check();
      test_check_errors();
      test_wrap();
      test_nop();
      test_reset_mid();
      test_start_while_busy();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
